demux_sched: RTL

DEMUX_SCHED -- requirements
Module: demux_sched

---
 rtl/demux_sched.sv | 109 ++++++++++
 1 files changed

// File: rtl/demux_sched.sv
// demux_sched: round-robin scheduler feeding a 1-to-4 demultiplexer.
//
// Each of four output channels raises its req bit when it wants the serial
// stream. One channel at a time holds the grant for up to BURST cycles.
// Every grant is followed by exactly one idle GAP cycle. The winner of the
// next grant is chosen round-robin, starting from the channel after the last
// one granted.
//
// Ports:
//   clk    - system clock, rising edge
//   rst    - synchronous active-high reset
//   req    - per-channel request, bit i = channel i wants data
//   din    - serial data bit routed to the granted channel
//   sel    - demux select, index of the granted channel (held through GAP)
//   x_out  - din delayed one cycle while granted, else 0
//   en     - high while a channel holds the grant
//   grant  - one-hot grant, all-zero when no channel is granted
//
// All outputs are registered. There is no combinational path from the
// inputs to the outputs.
module demux_sched #(
    parameter int BURST = 4,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       din,
    output logic [1:0] sel,
    output logic       x_out,
    output logic       en,
    output logic [3:0] grant
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       ptr;
    logic [1:0]       winner;
    logic             burst_done;

    // Round-robin pick. The loop walks offsets from far to near, so the
    // requester closest to ptr (mod 4) is written last and wins.
    always_comb begin
        winner = ptr;
        for (int i = 3; i >= 0; i--) begin
            if (req[ptr + 2'(i)]) begin
                winner = ptr + 2'(i);
            end
        end
    end

    assign burst_done = (cnt == CNT_W'(BURST - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sel   <= 2'b00;
            grant <= 4'b0000;
            en    <= 1'b0;
            x_out <= 1'b0;
            cnt   <= '0;
            ptr   <= 2'b00;
        end else begin
            case (state)
                GRANT: begin
                    // Release on a full burst or when the owner drops its
                    // request. Requests on other channels are ignored here.
                    if (burst_done || !req[sel]) begin
                        state <= GAP;
                        grant <= 4'b0000;
                        en    <= 1'b0;
                        x_out <= 1'b0;
                    end else begin
                        cnt   <= cnt + CNT_W'(1);
                        x_out <= din;
                    end
                end
                IDLE, GAP: begin
                    if (req != 4'b0000) begin
                        state <= GRANT;
                        sel   <= winner;
                        grant <= 4'b0001 << winner;
                        en    <= 1'b1;
                        x_out <= din;
                        cnt   <= '0;
                        ptr   <= winner + 2'd1;
                    end else begin
                        // sel keeps its last value while nothing is granted.
                        state <= IDLE;
                        x_out <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 4'b0000;
                    en    <= 1'b0;
                    x_out <= 1'b0;
                end
            endcase
        end
    end

endmodule
